// File: rtl/matrix_stream_pkg.sv
// Shared types and helpers for the matrix stream receiver.
// The optional checksum stage is controlled by MATRIX_STREAM_CHECKSUM_EN.
package matrix_stream_pkg;

  localparam int unsigned NUMBER_BITS_DEFAULT = 37;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RECEIVE = 2'd1,
    CHECK   = 2'd2,
    HOLD    = 2'd3
  } state_e;

  function automatic int unsigned bytes_per_number(input int unsigned bits);
    return (bits + 7) / 8;
  endfunction

  function automatic int unsigned elem_offset(input int unsigned r, input int unsigned c,
                                              input int unsigned i, input int unsigned dim,
                                              input int unsigned bits);
    return ((r * dim + c) * 2 + i) * bits;
  endfunction

endpackage

// File: rtl/matrix_stream_receiver_number_assembler.sv
// Builds one NUMBER_BITS value from an LSB-first byte stream. Bits of the last
// byte above NUMBER_BITS-1 are dropped.
module number_assembler
  import matrix_stream_pkg::*;
#(
  parameter int unsigned NUMBER_BITS = NUMBER_BITS_DEFAULT
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [7:0]             data_i,
  input  logic                   strobe_i,
  input  logic                   clear_i,
  output logic [NUMBER_BITS-1:0] number_c,
  output logic                   done_c
);

  localparam int unsigned BPN   = bytes_per_number(NUMBER_BITS);
  localparam int unsigned IDX_W = (BPN > 1) ? $clog2(BPN) : 1;

  logic [IDX_W-1:0]       byte_idx_q;
  logic [NUMBER_BITS-1:0] acc_q;
  logic                   last_c;

  assign last_c = (byte_idx_q == IDX_W'(BPN - 1));

  // Current byte merged over the bytes already collected; the top-bit masking
  // falls out of only mapping bits below NUMBER_BITS.
  always_comb begin
    number_c = acc_q;
    for (int unsigned b = 0; b < NUMBER_BITS; b++) begin
      if (byte_idx_q == IDX_W'(b / 8)) number_c[b] = data_i[b % 8];
    end
    done_c = strobe_i && !clear_i && last_c;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_idx_q <= '0;
      acc_q      <= '0;
    end else if (clear_i) begin
      byte_idx_q <= '0;
    end else if (strobe_i) begin
      acc_q      <= number_c;
      byte_idx_q <= last_c ? '0 : byte_idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/matrix_stream_receiver.sv
// Assembles a DIM x DIM complex matrix from the UART byte stream and holds it
// behind a valid/accept handshake. MATRIX_STREAM_CHECKSUM_EN adds an XOR check byte.
module matrix_stream_receiver
  import matrix_stream_pkg::*;
#(
  parameter int unsigned DIM         = 2,
  parameter int unsigned NUMBER_BITS = NUMBER_BITS_DEFAULT
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               start,
  input  logic [7:0]                         received_byte,
  input  logic                               received_ready,
  output logic [DIM*DIM*2*NUMBER_BITS-1:0]   matrix_out,
  output logic                               matrix_valid,
  input  logic                               matrix_accept,
  output logic                               busy,
  output logic                               error
);

  localparam int unsigned NUM_ELEMS = 2 * DIM * DIM;
  localparam int unsigned ELEM_W    = $clog2(NUM_ELEMS) + 1;
  localparam int unsigned MAT_W     = NUM_ELEMS * NUMBER_BITS;

  state_e                 state_q;
  logic [ELEM_W-1:0]      elem_q;
  logic [MAT_W-1:0]       matrix_q;
  logic                   valid_q;
  logic                   busy_q;
  logic                   clear_c;
  logic                   strobe_c;
  logic [NUMBER_BITS-1:0] number_c;
  logic                   done_c;
`ifdef MATRIX_STREAM_CHECKSUM_EN
  logic [7:0]             xor_q;
  logic                   error_q;
`endif

  // A start outside HOLD always restarts; its same-cycle byte is the command.
  assign clear_c  = start && (state_q != HOLD);
  assign strobe_c = received_ready && !start && (state_q == RECEIVE);

  number_assembler #(.NUMBER_BITS(NUMBER_BITS)) u_number_assembler (
    .clk      (clk),
    .reset    (reset),
    .data_i   (received_byte),
    .strobe_i (strobe_c),
    .clear_i  (clear_c),
    .number_c (number_c),
    .done_c   (done_c)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      elem_q   <= '0;
      matrix_q <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b0;
`ifdef MATRIX_STREAM_CHECKSUM_EN
      xor_q    <= '0;
      error_q  <= 1'b0;
`endif
    end else begin
`ifdef MATRIX_STREAM_CHECKSUM_EN
      error_q <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (start) begin
            state_q <= RECEIVE;
            busy_q  <= 1'b1;
            elem_q  <= '0;
`ifdef MATRIX_STREAM_CHECKSUM_EN
            xor_q   <= '0;
`endif
          end
        end
        RECEIVE: begin
          if (start) begin
            elem_q <= '0;
`ifdef MATRIX_STREAM_CHECKSUM_EN
            xor_q  <= '0;
`endif
          end else begin
`ifdef MATRIX_STREAM_CHECKSUM_EN
            if (received_ready) xor_q <= xor_q ^ received_byte;
`endif
            if (done_c) begin
              for (int unsigned r = 0; r < DIM; r++) begin
                for (int unsigned c = 0; c < DIM; c++) begin
                  for (int unsigned i = 0; i < 2; i++) begin
                    if (elem_q == ELEM_W'((r * DIM + c) * 2 + i))
                      matrix_q[elem_offset(r, c, i, DIM, NUMBER_BITS) +: NUMBER_BITS] <= number_c;
                  end
                end
              end
              elem_q <= elem_q + ELEM_W'(1);
              if (elem_q == ELEM_W'(NUM_ELEMS - 1)) begin
`ifdef MATRIX_STREAM_CHECKSUM_EN
                state_q <= CHECK;
`else
                state_q <= HOLD;
                valid_q <= 1'b1;
                busy_q  <= 1'b0;
`endif
              end
            end
          end
        end
`ifdef MATRIX_STREAM_CHECKSUM_EN
        CHECK: begin
          if (start) begin
            state_q <= RECEIVE;
            elem_q  <= '0;
            xor_q   <= '0;
          end else if (received_ready) begin
            busy_q <= 1'b0;
            if (received_byte == xor_q) begin
              state_q <= HOLD;
              valid_q <= 1'b1;
            end else begin
              state_q <= IDLE;
              error_q <= 1'b1;
            end
          end
        end
`endif
        HOLD: begin
          // Accept beats any simultaneous start; new traffic is ignored here.
          if (matrix_accept) begin
            state_q <= IDLE;
            valid_q <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign matrix_out   = matrix_q;
  assign matrix_valid = valid_q;
  assign busy         = busy_q;
`ifdef MATRIX_STREAM_CHECKSUM_EN
  assign error        = error_q;
`else
  assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_matrix_stream_receiver.sv
// Directed bench for matrix_stream_receiver: a 2x2/37-bit instance and a 3x3/20-bit instance.
module tb_matrix_stream_receiver;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic         start0, rdy0, acc0, valid0, busy0, err0;
  logic [7:0]   byte0;
  logic [295:0] mat0;
  logic         start3, rdy3, acc3, valid3, busy3, err3;
  logic [7:0]   byte3;
  logic [359:0] mat3;

  matrix_stream_receiver #(.DIM(2), .NUMBER_BITS(37)) u_dut0 (
    .clk(clk), .reset(reset), .start(start0), .received_byte(byte0),
    .received_ready(rdy0), .matrix_out(mat0), .matrix_valid(valid0),
    .matrix_accept(acc0), .busy(busy0), .error(err0)
  );

  matrix_stream_receiver #(.DIM(3), .NUMBER_BITS(20)) u_dut3 (
    .clk(clk), .reset(reset), .start(start3), .received_byte(byte3),
    .received_ready(rdy3), .matrix_out(mat3), .matrix_valid(valid3),
    .matrix_accept(acc3), .busy(busy3), .error(err3)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [39:0] raw;
    logic [36:0] exp;
    int          elem;
  } vec_t;

  vec_t         vecs[5];
  logic [7:0]   bq[$];
  logic [39:0]  raw0[8];
  logic [23:0]  raw3[18];
  logic [295:0] exp0;
  logic [359:0] exp3;
  logic [36:0]  slice0;

  task automatic check(input string name, input logic [511:0] act, input logic [511:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic r, input logic [7:0] b, input logic a);
    if (w == 0) begin
      start0 = s; rdy0 = r; byte0 = b; acc0 = a;
    end else begin
      start3 = s; rdy3 = r; byte3 = b; acc3 = a;
    end
    @(posedge clk);
    #1;
    start0 = 1'b0; rdy0 = 1'b0; acc0 = 1'b0;
    start3 = 1'b0; rdy3 = 1'b0; acc3 = 1'b0;
  endtask

  // Sends bq; valid must still be low before the final byte and high right after it.
  task automatic send_bytes(input int w, input string tag);
    logic v;
    for (int i = 0; i < bq.size() - 1; i++) drive(w, 1'b0, 1'b1, bq[i], 1'b0);
    v = (w == 0) ? valid0 : valid3;
    check({tag, "_valid_pre"}, 512'(v), 512'(1'b0));
    drive(w, 1'b0, 1'b1, bq[bq.size() - 1], 1'b0);
    v = (w == 0) ? valid0 : valid3;
    check({tag, "_valid_post"}, 512'(v), 512'(1'b1));
  endtask

  task automatic fill0();
    logic [7:0] x;
    logic [7:0] b;
    bq.delete();
    x = 8'h00;
    exp0 = '0;
    for (int e = 0; e < 8; e++) begin
      exp0[e*37 +: 37] = raw0[e][36:0];
      for (int k = 0; k < 5; k++) begin
        b = raw0[e][k*8 +: 8];
        bq.push_back(b);
        x = x ^ b;
      end
    end
`ifdef MATRIX_STREAM_CHECKSUM_EN
    bq.push_back(x);
`endif
  endtask

  task automatic fill3();
    logic [7:0] x;
    logic [7:0] b;
    bq.delete();
    x = 8'h00;
    exp3 = '0;
    for (int e = 0; e < 18; e++) begin
      exp3[e*20 +: 20] = raw3[e][19:0];
      for (int k = 0; k < 3; k++) begin
        b = raw3[e][k*8 +: 8];
        bq.push_back(b);
        x = x ^ b;
      end
    end
`ifdef MATRIX_STREAM_CHECKSUM_EN
    bq.push_back(x);
`endif
  endtask

  task automatic load_vec0(input int v);
    for (int e = 0; e < 8; e++)
      raw0[e] = (e == vecs[v].elem) ? vecs[v].raw : {8'hE0 | 8'(e), 32'h1234_5600 + 32'(e)};
    fill0();
  endtask

  initial begin
    vecs[0] = '{raw: 40'h05A82799A0, exp: 37'h05A82799A0, elem: 0};
    vecs[1] = '{raw: 40'hFF00000000, exp: 37'h1F00000000, elem: 3};
    vecs[2] = '{raw: 40'hFFFFFFFFFF, exp: 37'h1FFFFFFFFF, elem: 7};
    vecs[3] = '{raw: 40'h8000000001, exp: 37'h0000000001, elem: 5};
    vecs[4] = '{raw: 40'h1000000000, exp: 37'h1000000000, elem: 2};

    start0 = 0; rdy0 = 0; acc0 = 0; byte0 = 0;
    start3 = 0; rdy3 = 0; acc3 = 0; byte3 = 0;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_valid", 512'(valid0), 512'(1'b0));
    check("rst_busy",  512'(busy0),  512'(1'b0));
    check("rst_error", 512'(err0),   512'(1'b0));
    check("rst_mat",   512'(mat0),   512'(0));
    reset = 1'b0;

    // Table of full matrices, each with one hand-checked element.
    for (int v = 0; v < 5; v++) begin
      load_vec0(v);
      drive(0, 1'b1, 1'b1, 8'h4D, 1'b0);
      check($sformatf("v%0d_busy_start", v), 512'(busy0), 512'(1'b1));
      send_bytes(0, $sformatf("v%0d", v));
      check($sformatf("v%0d_mat", v), 512'(mat0), 512'(exp0));
      slice0 = mat0[vecs[v].elem*37 +: 37];
      check($sformatf("v%0d_elem", v), 512'(slice0), 512'(vecs[v].exp));
      check($sformatf("v%0d_busy_hold", v), 512'(busy0), 512'(1'b0));
      drive(0, 1'b0, 1'b0, 8'h00, 1'b1);
      check($sformatf("v%0d_acc_valid", v), 512'(valid0), 512'(1'b0));
    end

    // Restart after 13 bytes: only the second stream lands.
    load_vec0(1);
    drive(0, 1'b1, 1'b1, 8'h4D, 1'b0);
    for (int i = 0; i < 13; i++) drive(0, 1'b0, 1'b1, 8'hAA, 1'b0);
    drive(0, 1'b1, 1'b1, 8'h42, 1'b0);
    send_bytes(0, "restart");
    check("restart_mat", 512'(mat0), 512'(exp0));

    // HOLD ignores bytes and start; accept+start returns to IDLE with start lost.
    drive(0, 1'b1, 1'b1, 8'h55, 1'b0);
    drive(0, 1'b0, 1'b1, 8'h66, 1'b0);
    check("hold_mat",   512'(mat0),   512'(exp0));
    check("hold_valid", 512'(valid0), 512'(1'b1));
    drive(0, 1'b1, 1'b0, 8'h00, 1'b1);
    check("accstart_valid", 512'(valid0), 512'(1'b0));
    check("accstart_busy",  512'(busy0),  512'(1'b0));
    drive(0, 1'b0, 1'b1, 8'h77, 1'b0);
    check("idle_byte_busy",  512'(busy0),  512'(1'b0));
    check("idle_byte_valid", 512'(valid0), 512'(1'b0));

`ifdef MATRIX_STREAM_CHECKSUM_EN
    // Corrupted checksum byte: one-cycle error, no valid.
    load_vec0(0);
    bq[bq.size() - 1] = bq[bq.size() - 1] ^ 8'h01;
    drive(0, 1'b1, 1'b1, 8'h42, 1'b0);
    for (int i = 0; i < bq.size(); i++) drive(0, 1'b0, 1'b1, bq[i], 1'b0);
    check("cs_err_pulse", 512'(err0),   512'(1'b1));
    check("cs_err_valid", 512'(valid0), 512'(1'b0));
    check("cs_err_busy",  512'(busy0),  512'(1'b0));
    drive(0, 1'b0, 1'b0, 8'h00, 1'b0);
    check("cs_err_clear", 512'(err0),   512'(1'b0));
    check("cs_err_valid2", 512'(valid0), 512'(1'b0));
`endif

    // Reset mid-stream clears everything, including the held matrix contents.
    drive(0, 1'b1, 1'b1, 8'h4D, 1'b0);
    for (int i = 0; i < 10; i++) drive(0, 1'b0, 1'b1, 8'h3C, 1'b0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    check("mid_rst_mat",   512'(mat0),   512'(0));
    check("mid_rst_valid", 512'(valid0), 512'(1'b0));
    check("mid_rst_busy",  512'(busy0),  512'(1'b0));
    check("mid_rst_err",   512'(err0),   512'(1'b0));
    reset = 1'b0;

    // 3x3 with 20-bit numbers: 54 data bytes, element (2,1) imag at offset 300.
    for (int e = 0; e < 18; e++)
      raw3[e] = (e == 15) ? 24'hABCDEF : {4'hF, 4'(e), 16'h1000 + 16'(e)};
    fill3();
    drive(1, 1'b1, 1'b1, 8'h42, 1'b0);
    send_bytes(1, "dim3");
    check("dim3_mat",  512'(mat3), 512'(exp3));
    check("dim3_e15",  512'(mat3[300 +: 20]), 512'(20'hBCDEF));
    drive(1, 1'b0, 1'b0, 8'h00, 1'b1);
    check("dim3_acc_valid", 512'(valid3), 512'(1'b0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/matrix_stream_receiver.md
Name: matrix_stream_receiver

Overview:
- Parametrised successor to the coordinator's fixed 2x2 matrix decoder.
- Assembles a DIM x DIM complex matrix from the UART receive byte stream after the coordinator issues a start pulse (on command byte "M" or "B").
- Each real and imaginary part is NUMBER_BITS two's-complement, sent LSB byte first.
- The completed matrix is held and offered to the compute datapath through a valid/accept handshake.

Parameters:
- DIM, 2, matrix dimension (rows = cols = DIM); legal range 1..8.
- NUMBER_BITS, 37, width of one real or imaginary part.
- BYTES_PER_NUMBER, ceil(NUMBER_BITS/8) (5 by default), derived; must not be overridden.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse from the coordinator; begins a new matrix.
- received_byte  in  8  byte from the UART receiver.
- received_ready  in  1  received_byte is valid this cycle; each high cycle consumes one byte.
- matrix_out  out  DIM*DIM*2*NUMBER_BITS  flattened matrix; element (r,c,i) sits at bit offset ((r*DIM+c)*2+i)*NUMBER_BITS, where i=0 is real and i=1 is imaginary.
- matrix_valid  out  1  matrix_out is complete and stable.
- matrix_accept  in  1  consumer takes the matrix.
- busy  out  1  high in RECEIVE or CHECK.
- error  out  1  one-cycle pulse on checksum mismatch (optional feature only).

Behaviour:
- Reset: state IDLE; matrix_out=0, matrix_valid=0, busy=0, error=0; byte and element counters cleared. Reset mid-receive discards all partial data.
- States: IDLE, RECEIVE, CHECK (feature only), HOLD.
- IDLE:
  - start -> RECEIVE; byte_idx=0, elem_idx=0.
  - received_ready in IDLE is ignored.
  - A received_ready in the same cycle as start is not consumed; it is the command byte.
- RECEIVE:
  - Each received_ready cycle shifts received_byte into the current number at byte position byte_idx.
  - In the last byte (byte_idx = BYTES_PER_NUMBER-1), bits above NUMBER_BITS-1 are discarded. Default: top 3 bits of byte 5 are ignored.
  - Each completed number is written into matrix_out at offset elem_idx. Ordering is row-major, real part before imaginary part.
  - After element 2*DIM*DIM-1 completes -> HOLD (or CHECK with the feature).
- start in RECEIVE restarts: counters are zeroed, the same-cycle byte is discarded, and matrix_out is not cleared.
- HOLD:
  - matrix_valid=1 starting the cycle after the cycle in which the final byte was sampled (1-cycle latency).
  - matrix_out is stable while valid.
  - matrix_accept while valid -> IDLE; matrix_valid drops the next cycle.
  - start and received_ready are ignored in HOLD; the coordinator must not send a new matrix before accept.
- Simultaneous matrix_accept and start in HOLD: accept wins; start is lost.
- Values are not sign-extended or saturated; bits are stored exactly as received.
- Counters: byte_idx is clog2(BYTES_PER_NUMBER) bits; elem_idx is clog2(2*DIM*DIM)+1 bits; neither wraps in normal use.

Optional Feature:
- Macro: MATRIX_STREAM_CHECKSUM_EN.
- Enabled:
  - After the last data byte the block enters CHECK and waits for one extra received_ready byte.
  - Expected value: XOR of all data bytes as received, before masking of the discarded top bits.
  - Match -> HOLD.
  - Mismatch -> error pulses one cycle, matrix_valid stays 0, state returns to IDLE.
  - start in CHECK restarts as in RECEIVE.
- Disabled: no CHECK state; error is tied 0.

Decomposition:
- Package matrix_stream_pkg holds:
  - NUMBER_BITS default;
  - function bytes_per_number(bits);
  - function elem_offset(r,c,i,dim,bits);
  - state enum {IDLE, RECEIVE, CHECK, HOLD}.
- Sub-module number_assembler (parameter NUMBER_BITS):
  - inputs: byte, byte strobe, clear;
  - outputs: assembled number, done pulse;
  - owns byte_idx and the top-bit masking.

Test Plan:
- Default parameters; start, then 8 numbers with element (0,0) real = bytes A0 99 27 A8 05 -> that element reads 37'h5A82799A0; matrix_valid asserts exactly 1 cycle after the 40th byte.
- Number sent as bytes 00 00 00 00 FF -> stored value 37'h1F00000000 (top 3 bits dropped).
- start after 13 bytes, then a full 40-byte matrix -> only the second matrix appears; valid after byte 40 of the second stream.
- In HOLD, bytes with received_ready and a start pulse -> matrix_out unchanged; matrix_accept -> valid low the next cycle, state IDLE.
- DIM=3, NUMBER_BITS=20 (3 bytes per number) -> valid after 54 bytes; element (2,1) imaginary appears at offset 15*20.
- MATRIX_STREAM_CHECKSUM_EN:
  - correct XOR byte -> valid;
  - corrupted checksum byte -> one-cycle error pulse, valid stays 0;
  - reset mid-stream -> all outputs are 0 the next cycle.
